// File: rtl/or2_tester.sv
// rtl/or2_tester.sv - exhaustive stimulus and checker for a 2-input OR cell
// Walks (B,A)=00..11, holds each vector HOLD cycles, samples y_in at SETTLE, counts mismatches.
module or2_tester #(
  parameter int HOLD   = 10,
  parameter int SETTLE = 3,
  parameter int LOOPS  = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       pass_out,
  output logic [7:0] err_cnt_out
);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [HW-1:0] SETTLE_AT = HW'(SETTLE);
  localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t        state_q;
  logic [1:0]    vec_q;
  logic [HW-1:0] hold_q;
  logic [LW-1:0] loop_q;
  logic          a_q, b_q, busy_q, done_q, pass_q;
  logic [7:0]    err_q, err_d;
  logic          mismatch;
  logic          sample;

  // An unknown y_in falls through to the default, so X/Z counts as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (y_in == (a_q | b_q)) mismatch = 1'b0;
  end

  assign sample = (state_q == DRIVE) && (hold_q == SETTLE_AT);

  always_comb begin
    err_d = err_q;
    if (sample && mismatch && (err_q != 8'hFF)) err_d = err_q + 8'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      loop_q  <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_in) begin
            state_q <= DRIVE;
            vec_q   <= '0;
            hold_q  <= '0;
            loop_q  <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
          end
        end
        DRIVE: begin
          err_q <= err_d;
          if (hold_q == HOLD_LAST) begin
            // pass uses err_d so a sample on the final edge is already included
            if ((vec_q == 2'd3) && (loop_q == LOOP_LAST)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              pass_q  <= (err_d == 8'd0);
              a_q     <= 1'b0;
              b_q     <= 1'b0;
            end else begin
              hold_q     <= '0;
              vec_q      <= vec_q + 2'd1;
              {b_q, a_q} <= vec_q + 2'd1;
              if (vec_q == 2'd3) loop_q <= loop_q + LW'(1);
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign pass_out    = pass_q;
  assign err_cnt_out = err_q;
endmodule

// File: tb/tb_or2_tester.sv
// tb/tb_or2_tester.sv - self-checking bench for or2_tester
module tb_or2_tester;
  localparam int HOLD = 10, SETTLE = 3;

  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, y = 1'b0;
  logic a, b, busy, done, pass;
  logic [7:0] err;
  logic start_s = 1'b0, y_s = 1'b0;
  logic a_s, b_s, busy_s, done_s, pass_s;
  logic [7:0] err_s;
  logic start_l = 1'b0;
  logic y_l;
  logic a_l, b_l, busy_l, done_l, pass_l;
  logic [7:0] err_l;

  int checks = 0, failures = 0;

  or2_tester #(.HOLD(HOLD), .SETTLE(SETTLE), .LOOPS(1)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .y_in(y),
    .a_out(a), .b_out(b), .busy_out(busy), .done_out(done),
    .pass_out(pass), .err_cnt_out(err));

  or2_tester #(.HOLD(4), .SETTLE(3), .LOOPS(1)) dut_s (
    .clk_in(clk), .rst_in(rst), .start_in(start_s), .y_in(y_s),
    .a_out(a_s), .b_out(b_s), .busy_out(busy_s), .done_out(done_s),
    .pass_out(pass_s), .err_cnt_out(err_s));

  // NOR cell under test: every sample mismatches
  assign y_l = ~(a_l | b_l);
  or2_tester #(.HOLD(4), .SETTLE(3), .LOOPS(100)) dut_l (
    .clk_in(clk), .rst_in(rst), .start_in(start_l), .y_in(y_l),
    .a_out(a_l), .b_out(b_l), .busy_out(busy_l), .done_out(done_l),
    .pass_out(pass_l), .err_cnt_out(err_l));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ymap;
    int         exp_err;
    int         exp_pass;
    string      name;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: one sample per vector per loop, mismatch when cell answer differs from OR.
  function automatic int model_err(input logic [3:0] ymap, input int loops);
    int n = 0;
    for (int v = 0; v < 4; v++)
      if (ymap[v] != (v != 0)) n++;
    n = n * loops;
    return (n > 255) ? 255 : n;
  endfunction

  task automatic run(input string name, input logic [3:0] ymap, input int want_err,
                     input bit pulses, input bit hold_start);
    int ab_bad = 0, flag_bad = 0, v, n;
    @(negedge clk); start = 1'b1;
    for (int t = 0; t < 4 * HOLD; t++) begin
      @(negedge clk);
      v = (t / HOLD) % 4;
      start = (pulses && (t == 5 || t == 39)) || (hold_start && t >= 39);
      if ({b, a} != 2'(v)) ab_bad++;
      if (!busy || done) flag_bad++;
      y = (t % HOLD == SETTLE) ? ymap[v] : 1'($urandom);
    end
    check({name, "_ab_seq"}, ab_bad, 0);
    check({name, "_busy_during_drive"}, flag_bad, 0);
    @(negedge clk);
    check({name, "_done"}, int'(done), 1);
    check({name, "_busy_in_done"}, int'(busy), 0);
    check({name, "_err"}, int'(err), want_err);
    check({name, "_pass"}, int'(pass), int'(want_err == 0));
    check({name, "_ab_idle"}, int'({b, a}), 0);
    @(negedge clk);
    if (!hold_start) begin
      start = 1'b0;
      check({name, "_done_single"}, int'(done), 0);
      check({name, "_err_held"}, int'(err), want_err);
      check({name, "_pass_held"}, int'(pass), int'(want_err == 0));
    end else begin
      check({name, "_idle_gap"}, int'(busy), 0);
      @(negedge clk);
      start = 1'b0;
      check({name, "_restart"}, int'(busy), 1);
      n = 0;
      while (!done && n < 60) begin @(negedge clk); n++; end
      check({name, "_restart_len"}, n, 4 * HOLD);
      @(negedge clk);
    end
  endtask

  task automatic run_s(input string name, input logic [3:0] ymap, input int want_err);
    @(negedge clk); start_s = 1'b1;
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      start_s = 1'b0;
      y_s = ymap[t / 4];
    end
    @(negedge clk);
    check({name, "_done"}, int'(done_s), 1);
    check({name, "_err"}, int'(err_s), want_err);
    check({name, "_pass"}, int'(pass_s), int'(want_err == 0));
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl[4];
    int n, cnt;
    logic [3:0] m;
    tbl[0] = '{4'b1110, 0, 1, "ideal"};
    tbl[1] = '{4'b0000, 3, 0, "stuck0"};
    tbl[2] = '{4'b1111, 1, 0, "stuck1"};
    tbl[3] = '{4'b0001, 4, 0, "nor"};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({a, b, busy, done, pass, err}), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("idle_no_done", cnt, 0);

    for (int i = 0; i < 4; i++) begin
      check({tbl[i].name, "_tbl_pass"}, int'(tbl[i].exp_err == 0), tbl[i].exp_pass);
      run(tbl[i].name, tbl[i].ymap, tbl[i].exp_err, 1'b0, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      m = 4'($urandom_range(0, 15));
      run($sformatf("rand%0d_m%0h", i, m), m, model_err(m, 1), 1'b0, 1'b0);
    end

    @(negedge clk); start = 1'b1; y = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    check("midrun_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1 check("rst_async_outputs", int'({a, b, busy, done, pass, err}), 0);
    @(negedge clk); rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("rst_no_done", cnt, 0);
    run("after_rst", 4'b1110, 0, 1'b0, 1'b0);

    run("start_pulses", 4'b1110, 0, 1'b1, 1'b0);
    run("start_held", 4'b1110, 0, 1'b0, 1'b1);

    run_s("last_sample_bad", 4'b0110, 1);
    run_s("last_sample_good", 4'b1110, 0);

    @(negedge clk); start_l = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      start_l = 1'b0;
    end while (!done_l && n < 2000);
    check("sat_latency", n, 4 * 4 * 100 + 1);
    check("sat_err", int'(err_l), model_err(4'b0001, 100));
    check("sat_pass", int'(pass_l), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
